// File: rtl/ascii_hex_decoder_pkg.sv
// Shared definitions for the ASCII-hex decoder: FSM states and the ASCII
// character codes that bound the hex digit ranges and name the delimiters.
package ascii_hex_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] CHAR_0     = 8'h30;
    localparam logic [7:0] CHAR_9     = 8'h39;
    localparam logic [7:0] CHAR_UA    = 8'h41;
    localparam logic [7:0] CHAR_UF    = 8'h46;
    localparam logic [7:0] CHAR_LA    = 8'h61;
    localparam logic [7:0] CHAR_LF    = 8'h66;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_NL    = 8'h0A;
    localparam logic [7:0] CHAR_COMMA = 8'h2C;

endpackage

// File: rtl/ascii_hex_classify.sv
// Combinational character classifier: tells whether an ASCII code is a hex
// digit (and its value) or one of the word delimiters.
module ascii_hex_classify
    import ascii_hex_decoder_pkg::*;
(
    input  logic [7:0] char,
    output logic       is_digit,
    output logic       is_delim,
    output logic [3:0] nibble
);

    // Map the character onto its class; lower-case letters decode like upper case.
    always_comb begin
        is_digit = 1'b0;
        is_delim = 1'b0;
        nibble   = 4'h0;
        if (char >= CHAR_0 && char <= CHAR_9) begin
            is_digit = 1'b1;
            nibble   = 4'(char - CHAR_0);
        end else if (char >= CHAR_UA && char <= CHAR_UF) begin
            is_digit = 1'b1;
            nibble   = 4'(char - CHAR_UA + 8'd10);
        end else if (char >= CHAR_LA && char <= CHAR_LF) begin
            is_digit = 1'b1;
            nibble   = 4'(char - CHAR_LA + 8'd10);
        end else if (char == CHAR_SPACE || char == CHAR_CR ||
                     char == CHAR_NL    || char == CHAR_COMMA) begin
            is_delim = 1'b1;
        end
    end

endmodule

// File: rtl/ascii_hex_decoder.sv
// Streaming ASCII-hex to binary decoder. Hex digits are shifted in MSB-first;
// a full word or a delimiter after at least one digit presents the word on a
// valid/ready port, and an illegal character discards the partial word.
module ascii_hex_decoder
    import ascii_hex_decoder_pkg::*;
#(
    parameter  int NBR_OF_NIBBLES = 4,
    localparam int CNT_W          = $clog2(NBR_OF_NIBBLES + 1)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [7:0]                  char_in,
    input  logic                        char_valid,
    output logic                        char_ready,
    output logic [NBR_OF_NIBBLES*4-1:0] data_out,
    output logic [CNT_W-1:0]            data_nibbles,
    output logic                        data_valid,
    input  logic                        data_ready,
    output logic                        error
);

    localparam int               W         = NBR_OF_NIBBLES * 4;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NBR_OF_NIBBLES);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    state_t           state, state_next;
    logic [W-1:0]     acc, acc_next, acc_shift;
    logic [CNT_W-1:0] count, count_next, count_inc;
    logic [W-1:0]     out_next;
    logic [CNT_W-1:0] nibbles_next;
    logic             valid_next, error_next;

    logic             is_digit, is_delim;
    logic [3:0]       nibble;
    logic             accept;

    ascii_hex_classify u_classify (
        .char     (char_in),
        .is_digit (is_digit),
        .is_delim (is_delim),
        .nibble   (nibble)
    );

    // Characters are refused only while a word waits on the output port.
    assign char_ready = (state != HOLD);
    assign accept     = char_valid && char_ready;
    assign acc_shift  = (acc << 4) | W'(nibble);
    assign count_inc  = count + ONE_CNT;

    // Next-state and next-output decisions for one accepted character or output handshake.
    always_comb begin
        state_next   = state;
        acc_next     = acc;
        count_next   = count;
        out_next     = data_out;
        nibbles_next = data_nibbles;
        valid_next   = data_valid;
        error_next   = 1'b0;
        case (state)
            HOLD: begin
                if (data_valid && data_ready) begin
                    valid_next = 1'b0;
                    acc_next   = '0;
                    count_next = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                if (accept) begin
                    if (is_digit) begin
                        acc_next   = acc_shift;
                        count_next = count_inc;
                        if (count_inc == FULL_CNT) begin
                            out_next     = acc_shift;
                            nibbles_next = FULL_CNT;
                            valid_next   = 1'b1;
                            state_next   = HOLD;
                        end else begin
                            state_next = ACCUM;
                        end
                    end else if (is_delim) begin
                        if (count != '0) begin
                            out_next     = acc;
                            nibbles_next = count;
                            valid_next   = 1'b1;
                            state_next   = HOLD;
                        end
                    end else begin
                        error_next = 1'b1;
                        acc_next   = '0;
                        count_next = '0;
                        state_next = IDLE;
                    end
                end
            end
        endcase
    end

    // Register FSM state, accumulator and all outputs; reset drops any pending word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            acc          <= '0;
            count        <= '0;
            data_out     <= '0;
            data_nibbles <= '0;
            data_valid   <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_next;
            acc          <= acc_next;
            count        <= count_next;
            data_out     <= out_next;
            data_nibbles <= nibbles_next;
            data_valid   <= valid_next;
            error        <= error_next;
        end
    end

endmodule

// File: tb/tb_ascii_hex_decoder.sv
// Testbench for ascii_hex_decoder: a 4-digit and a 1-digit instance share the
// same character stream and are compared every cycle against a word-level
// model, with directed scenarios followed by random traffic.
module tb_ascii_hex_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        data_ready;

    logic        ready4, valid4, err4;
    logic [15:0] out4;
    logic [2:0]  nib4;
    logic        ready1, valid1, err1;
    logic [3:0]  out1;
    logic [0:0]  nib1;

    int checks = 0;
    int errors = 0;

    int m_n [2] = '{4, 1};
    bit m_hold [2];
    bit m_err [2];
    int m_val [2];
    int m_cnt [2];
    int m_out [2];
    int m_nib [2];

    string      hex_chars;
    logic [7:0] delims [4] = '{8'h20, 8'h0D, 8'h0A, 8'h2C};

    ascii_hex_decoder #(.NBR_OF_NIBBLES(4)) dut4 (
        .clk          (clk),
        .reset_n      (reset_n),
        .char_in      (char_in),
        .char_valid   (char_valid),
        .char_ready   (ready4),
        .data_out     (out4),
        .data_nibbles (nib4),
        .data_valid   (valid4),
        .data_ready   (data_ready),
        .error        (err4)
    );

    ascii_hex_decoder #(.NBR_OF_NIBBLES(1)) dut1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .char_in      (char_in),
        .char_valid   (char_valid),
        .char_ready   (ready1),
        .data_out     (out1),
        .data_nibbles (nib1),
        .data_valid   (valid1),
        .data_ready   (data_ready),
        .error        (err1)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Character class from the ASCII table: 0 digit, 1 delimiter, 2 illegal.
    function automatic int charKind(input logic [7:0] c, output int value);
        value = 0;
        if (c >= "0" && c <= "9") begin
            value = int'(c) - 48;
            return 0;
        end
        if (c >= "A" && c <= "F") begin
            value = int'(c) - 65 + 10;
            return 0;
        end
        if (c >= "a" && c <= "f") begin
            value = int'(c) - 97 + 10;
            return 0;
        end
        if (c == 8'h20 || c == 8'h0D || c == 8'h0A || c == 8'h2C) return 1;
        return 2;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_hold[k] = 0;
            m_err[k]  = 0;
            m_val[k]  = 0;
            m_cnt[k]  = 0;
            m_out[k]  = 0;
            m_nib[k]  = 0;
        end
    endtask

    // Advance the word-level model of both instances by one clock edge.
    task automatic modelStep(input logic cv, input logic [7:0] c, input logic dr);
        int kind;
        int value;
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 0;
            if (m_hold[k]) begin
                if (dr) begin
                    m_hold[k] = 0;
                    m_val[k]  = 0;
                    m_cnt[k]  = 0;
                end
            end else if (cv) begin
                kind = charKind(c, value);
                if (kind == 0) begin
                    m_val[k] = (m_val[k] * 16 + value) % (1 << (4 * m_n[k]));
                    m_cnt[k] = m_cnt[k] + 1;
                    if (m_cnt[k] == m_n[k]) begin
                        m_hold[k] = 1;
                        m_out[k]  = m_val[k];
                        m_nib[k]  = m_n[k];
                    end
                end else if (kind == 1) begin
                    if (m_cnt[k] > 0) begin
                        m_hold[k] = 1;
                        m_out[k]  = m_val[k];
                        m_nib[k]  = m_cnt[k];
                    end
                end else begin
                    m_err[k] = 1;
                    m_val[k] = 0;
                    m_cnt[k] = 0;
                end
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("ready4", ready4, !m_hold[0]);
        checkOutput("valid4", valid4, m_hold[0]);
        checkOutput("data4",  out4,   m_out[0]);
        checkOutput("nib4",   nib4,   m_nib[0]);
        checkOutput("err4",   err4,   m_err[0]);
        checkOutput("ready1", ready1, !m_hold[1]);
        checkOutput("valid1", valid1, m_hold[1]);
        checkOutput("data1",  out1,   m_out[1]);
        checkOutput("nib1",   nib1,   m_nib[1]);
        checkOutput("err1",   err1,   m_err[1]);
    endtask

    // One clock cycle: check outputs at the falling edge, then drive new inputs.
    task automatic applyStimulus(input logic cv, input logic [7:0] c, input logic dr);
        @(negedge clk);
        checkAll();
        char_valid = cv;
        char_in    = c;
        data_ready = dr;
        modelStep(cv, c, dr);
        @(posedge clk);
    endtask

    task automatic sendString(input string s, input logic dr);
        for (int i = 0; i < s.len(); i++) applyStimulus(1'b1, s[i], dr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        logic [7:0] c;
        int         r;
        hex_chars  = "0123456789ABCDEFabcdef";
        reset_n    = 1'b0;
        char_valid = 1'b0;
        char_in    = 8'h00;
        data_ready = 1'b1;
        modelReset();

        #12;
        checkOutput("rst_ready", ready4, 1);
        checkOutput("rst_valid", valid4, 0);
        checkOutput("rst_data",  out4,   0);
        checkOutput("rst_err",   err4,   0);
        @(negedge clk);
        reset_n = 1'b1;

        // Full word, back to back.
        sendString("1A2f", 1'b1);
        #1;
        checkOutput("t1_valid", valid4, 1);
        checkOutput("t1_data",  out4,   16'h1A2F);
        checkOutput("t1_nib",   nib4,   4);
        idle(2);

        // Partial word closed by a delimiter, then delimiters alone.
        sendString("7F\r", 1'b1);
        #1;
        checkOutput("t2_data", out4, 16'h007F);
        checkOutput("t2_nib",  nib4, 2);
        sendString("\n \n", 1'b1);
        idle(2);

        // Illegal character discards the partial word.
        sendString("1G", 1'b1);
        #1;
        checkOutput("t3_err",   err4,   1);
        checkOutput("t3_valid", valid4, 0);
        sendString("BEEF", 1'b1);
        #1;
        checkOutput("t3_data", out4, 16'hBEEF);
        idle(2);

        // Backpressure holds the word and refuses characters.
        sendString("0123", 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, "4", 1'b0);
            #1;
            checkOutput("t4_ready", ready4, 0);
            checkOutput("t4_data",  out4,   16'h0123);
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        sendString("4567", 1'b1);
        #1;
        checkOutput("t4_data2", out4, 16'h4567);
        idle(2);

        // Asynchronous reset between edges drops the partial word.
        sendString("12", 1'b1);
        #3;
        reset_n    = 1'b0;
        char_valid = 1'b0;
        #1;
        modelReset();
        checkOutput("t5_valid", valid4, 0);
        checkOutput("t5_data",  out4,   0);
        checkOutput("t5_ready", ready4, 1);
        @(negedge clk);
        reset_n = 1'b1;
        sendString("ABCD", 1'b1);
        #1;
        checkOutput("t5_data2", out4, 16'hABCD);
        idle(2);

        // One-digit instance: each digit is a word, the comma is ignored.
        sendString("9", 1'b1);
        #1;
        checkOutput("t6_data_a", out1, 4'h9);
        checkOutput("t6_nib_a",  nib1, 1);
        sendString(",a", 1'b1);
        #1;
        checkOutput("t6_data_b", out1, 4'hA);
        checkOutput("t6_err",    err1, 0);
        idle(3);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) c = hex_chars[$urandom_range(0, 21)];
            else if (r < 8) c = delims[$urandom_range(0, 3)];
            else c = 8'($urandom);
            applyStimulus(($urandom % 4) != 0, c, ($urandom % 3) != 0);
        end
        idle(2);
        @(negedge clk);
        checkAll();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
